conv_run_ctrl: RTL and testbench
================================

CONV_RUN_CTRL -- requirements
Module: conv_run_ctrl

Interface
REQ-001 Parameter ACC_WIDTH, default 12: width of each convolution result.
REQ-002 Parameter TIMEOUT, default 1023: maximum number of idle cycles allowed between progress events before an error is flagged.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_run  in  1  single-cycle request to start a convolution run.
REQ-007 kern_wr_en / kern_wr_addr / kern_wr_data  in  1/4/4  kernel register write strobe, index 0-8, value 0-9.
REQ-008 conv_start  out  1  start pulse to the convolution engine.
REQ-009 conv_kernel / conv_kernel_valid  out  4/1  kernel element and its strobe to the engine.
REQ-010 conv_kernel_ready  in  1  engine is accepting kernel elements.
REQ-011 conv_out_valid / conv_out_elem / conv_out_row_idx / conv_out_col_idx / conv_out_last  in  1/ACC_WIDTH/4/4/1  engine result stream.
REQ-012 rd_addr / rd_data  in 7 / out ACC_WIDTH  result buffer read port.
REQ-013 run_busy / run_done / run_err  out  1/1/1  controller status.
REQ-014 result_count  out  7  results captured in the current run.
REQ-015 run_cycles  out  16  cycles from conv_start to conv_out_last.

Function
REQ-016 The block SHALL implement states IDLE, START, FEED, COLLECT, DONE and ERR.
REQ-017 IDLE/DONE/ERR + req_run SHALL go to START; clear result_count, run_done, run_err and run_cycles; set run_busy.
REQ-018 START SHALL assert conv_start for exactly one cycle, reset feed_idx to 0, and go to FEED.
REQ-019 FEED SHALL drive conv_kernel_valid=1 and conv_kernel=kmem[feed_idx] combinationally while feed_idx<9.
- A transfer is valid&ready at a rising edge; it increments feed_idx.
- The 9th transfer SHALL move to COLLECT; the strobe is never asserted for feed_idx>=9.
REQ-020 COLLECT SHALL, on conv_out_valid:
- write conv_out_elem to buf[row_idx*10+col_idx] (80 entries);
- increment result_count.
REQ-021 conv_out_last in COLLECT with pre-increment result_count==79 SHALL go to DONE, clear run_busy and set run_done; any other count SHALL go to ERR.
REQ-022 run_cycles SHALL increment every cycle from the cycle after START through the cycle conv_out_last is accepted, saturate at 16'hFFFF, and hold until the next START.
REQ-023 Timeout counter:
- clears on START, on each kernel transfer and on each conv_out_valid;
- increments otherwise in FEED/COLLECT;
- reaching TIMEOUT SHALL go to ERR (run_err=1, run_busy=0).
REQ-024 req_run in START/FEED/COLLECT SHALL be ignored.
REQ-025 Kernel writes with kern_wr_addr<=8 SHALL update kmem in IDLE/DONE/ERR; writes in START/FEED/COLLECT, and writes with kern_wr_addr>8, SHALL be ignored.
REQ-026 Simultaneous req_run and a kernel write in IDLE SHALL apply the write first, so the new value is fed in the same run.
REQ-027 rd_data SHALL be registered with 1-cycle latency (buf[rd_addr]), return 0 for rd_addr>=80, and be readable in every state.
REQ-028 conv_out_valid outside COLLECT SHALL be ignored (no buffer write, no count change).
REQ-029 Out-of-range indices (row_idx>7 or col_idx>9) SHALL not write the buffer and SHALL go to ERR.

Reset
REQ-030 Reset SHALL force IDLE, with conv_start, conv_kernel_valid, run_busy, run_done, run_err, result_count, run_cycles, rd_data, feed_idx, the timeout counter and all kmem entries at 0.
REQ-031 Buffer contents SHALL not be reset.
REQ-032 Reset mid-run SHALL abort immediately; no conv_start or kernel strobe in the cycle after rst deasserts.

Verification
REQ-033 Kernel all 1s, req_run, real engine -> 9 transfers; run_done=1, result_count=80; rd_addr=0 reads 40 one cycle later.
REQ-034 Kernel kmem[4]=1, others 0 -> rd_addr=0 reads 1; rd_addr=79 reads 6; rd_addr=100 reads 0.
REQ-035 Engine model holding conv_kernel_ready=0 -> run_err=1 after TIMEOUT cycles, run_busy=0; a following req_run restarts cleanly.
REQ-036 Model asserting conv_out_last after 50 results -> ERR, result_count=50; req_run or kernel write during the run ignored.
REQ-037 rst pulsed during COLLECT -> all outputs 0 next cycle; next req_run completes normally with 80 results.

Source files
------------

// File: rtl/conv_run_ctrl_if.sv
// conv_run_ctrl_if -- link between the run controller and the convolution engine.
//   conv_start                 : one-cycle run start pulse (ctrl -> engine)
//   conv_kernel/_valid/_ready  : kernel element stream, valid&ready handshake
//   conv_out_valid/_elem       : result stream from the engine (no back-pressure)
//   conv_out_row_idx/_col_idx  : result position, rows 0-7, cols 0-9
//   conv_out_last              : marks the final result of a run
// master = controller side, slave = engine side.
interface conv_run_ctrl_if #(
  parameter int ACC_WIDTH = 12
);
  logic                 conv_start;
  logic [3:0]           conv_kernel;
  logic                 conv_kernel_valid;
  logic                 conv_kernel_ready;
  logic                 conv_out_valid;
  logic [ACC_WIDTH-1:0] conv_out_elem;
  logic [3:0]           conv_out_row_idx;
  logic [3:0]           conv_out_col_idx;
  logic                 conv_out_last;

  modport master (
    output conv_start, conv_kernel, conv_kernel_valid,
    input  conv_kernel_ready, conv_out_valid, conv_out_elem,
           conv_out_row_idx, conv_out_col_idx, conv_out_last
  );

  modport slave (
    input  conv_start, conv_kernel, conv_kernel_valid,
    output conv_kernel_ready, conv_out_valid, conv_out_elem,
           conv_out_row_idx, conv_out_col_idx, conv_out_last
  );
endinterface

// File: rtl/conv_run_ctrl.sv
// conv_run_ctrl -- sequences one convolution run: feeds the 9-entry kernel to the
// engine, captures the 8x10 result stream into a buffer and reports status.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   eng (master)            : engine link (start, kernel stream, result stream)
//   i_req_run               : start request, honoured only in IDLE/DONE/ERR
//   i_kern_wr_en/addr/data  : kernel register write, honoured only in IDLE/DONE/ERR
//   i_rd_addr / o_rd_data   : result buffer read, 1-cycle latency, 0 beyond entry 79
//   o_run_busy/done/err     : run status
//   o_result_count          : results captured in the current run
//   o_run_cycles            : cycles from start through acceptance of the last result
module conv_run_ctrl #(
  parameter int ACC_WIDTH = 12,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_run_ctrl_if.master      eng,
  input  logic                 i_req_run,
  input  logic                 i_kern_wr_en,
  input  logic [3:0]           i_kern_wr_addr,
  input  logic [3:0]           i_kern_wr_data,
  input  logic [6:0]           i_rd_addr,
  output logic [ACC_WIDTH-1:0] o_rd_data,
  output logic                 o_run_busy,
  output logic                 o_run_done,
  output logic                 o_run_err,
  output logic [6:0]           o_result_count,
  output logic [15:0]          o_run_cycles
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_COLLECT, S_DONE, S_ERR} state_t;

  state_t               r_state, w_next;
  logic [3:0]           r_kmem [0:8];
  logic [3:0]           r_feed_idx;
  logic [TO_W-1:0]      r_to_cnt;
  logic [ACC_WIDTH-1:0] r_buf [0:79];
  logic [ACC_WIDTH-1:0] r_rd_data;
  logic                 r_busy, r_done, r_err;
  logic [6:0]           r_result_count;
  logic [15:0]          r_run_cycles;

  logic       w_idle, w_active, w_feeding, w_xfer, w_acc, w_oob, w_wr, w_to_hit, w_go_start;
  logic [6:0] w_waddr;

  assign w_idle    = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_active  = (r_state == S_FEED) || (r_state == S_COLLECT);
  assign w_feeding = (r_state == S_FEED) && (r_feed_idx < 4'd9);
  assign w_xfer    = w_feeding && eng.conv_kernel_ready;
  assign w_acc     = (r_state == S_COLLECT) && eng.conv_out_valid;
  assign w_oob     = (eng.conv_out_row_idx > 4'd7) || (eng.conv_out_col_idx > 4'd9);
  assign w_wr      = w_acc && !w_oob;
  assign w_waddr   = 7'(eng.conv_out_row_idx) * 7'd10 + 7'(eng.conv_out_col_idx);
  assign w_go_start = w_idle && i_req_run;
  // The idle counter would reach TIMEOUT on this edge with no progress event.
  assign w_to_hit  = w_active && !w_xfer && !w_acc && (r_to_cnt == TO_W'(TIMEOUT - 1));

  assign eng.conv_start        = (r_state == S_START);
  assign eng.conv_kernel_valid = w_feeding;
  assign eng.conv_kernel       = w_feeding ? r_kmem[r_feed_idx] : 4'd0;

  assign o_rd_data      = r_rd_data;
  assign o_run_busy     = r_busy;
  assign o_run_done     = r_done;
  assign o_run_err      = r_err;
  assign o_result_count = r_result_count;
  assign o_run_cycles   = r_run_cycles;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_req_run) w_next = S_START;
      S_START:               w_next = S_FEED;
      S_FEED: begin
        if (w_to_hit)                             w_next = S_ERR;
        else if (w_xfer && r_feed_idx == 4'd8)    w_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_acc) begin
          if (w_oob)                   w_next = S_ERR;
          else if (eng.conv_out_last)  w_next = (r_result_count == 7'd79) ? S_DONE : S_ERR;
        end else if (w_to_hit) begin
          w_next = S_ERR;
        end
      end
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_kmem[i] <= '0;
      r_feed_idx     <= '0;
      r_to_cnt       <= '0;
      r_rd_data      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_result_count <= '0;
      r_run_cycles   <= '0;
    end else begin
      // Kernel write lands on the same edge that accepts req_run, so it is fed in that run.
      if (w_idle && i_kern_wr_en && (i_kern_wr_addr <= 4'd8))
        r_kmem[i_kern_wr_addr] <= i_kern_wr_data;

      r_rd_data <= (i_rd_addr < 7'd80) ? r_buf[i_rd_addr] : '0;

      if (r_state == S_START) r_feed_idx <= '0;
      else if (w_xfer)        r_feed_idx <= r_feed_idx + 4'd1;

      if ((r_state == S_START) || w_xfer || w_acc) r_to_cnt <= '0;
      else if (w_active)                           r_to_cnt <= r_to_cnt + TO_W'(1);

      // FEED/COLLECT span exactly the cycle after START through the last-result cycle.
      if (w_go_start)                              r_run_cycles <= '0;
      else if (w_active && r_run_cycles != 16'hFFFF) r_run_cycles <= r_run_cycles + 16'd1;

      if (w_go_start) begin
        r_result_count <= '0;
        r_busy         <= 1'b1;
        r_done         <= 1'b0;
        r_err          <= 1'b0;
      end else begin
        if (w_wr) r_result_count <= r_result_count + 7'd1;
        if ((r_state == S_COLLECT) && (w_next == S_DONE)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        if ((r_state != S_ERR) && (w_next == S_ERR)) begin
          r_busy <= 1'b0;
          r_err  <= 1'b1;
        end
      end
    end
  end

  // Result storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_buf[w_waddr] <= eng.conv_out_elem;
  end
endmodule

// File: tb/tb_conv_run_ctrl.sv
module tb_conv_run_ctrl;
  localparam int AW = 12;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_run = 1'b0, kwe = 1'b0;
  logic [3:0]    kwa = '0, kwd = '0;
  logic [6:0]    rd_addr = '0;
  logic [AW-1:0] rd_data;
  logic          busy, done, err;
  logic [6:0]    rcount;
  logic [15:0]   rcyc;

  conv_run_ctrl_if #(.ACC_WIDTH(AW)) eng_if ();

  conv_run_ctrl #(.ACC_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .eng            (eng_if),
    .i_req_run      (req_run),
    .i_kern_wr_en   (kwe),
    .i_kern_wr_addr (kwa),
    .i_kern_wr_data (kwd),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_run_busy     (busy),
    .o_run_done     (done),
    .o_run_err      (err),
    .o_result_count (rcount),
    .o_run_cycles   (rcyc)
  );

  int total = 0, bad = 0;
  int img [10][12];
  int kmodel [9];
  int refbuf [80];
  int krx [9];
  int exp_kq [$];
  int rd_q [$];
  int rd_aq [$];
  logic rd_req = 1'b0;
  int mode = 0;
  bit eng_abort = 1'b0;
  int cyc = 0, t_s = 0, t_l = 0;
  int e_st = 0, nk = 0, ridx = 0, ntot = 0;
  int n_start = 0, n_runs = 0;
  bit rdy;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int conv_k(input int k [9], input int idx);
    int s = 0;
    for (int i = 0; i < 9; i++) s += k[i] * img[idx / 10 + i / 3][idx % 10 + i % 3];
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: takes 9 kernel elements with random ready, then streams results.
  always @(negedge clk) begin
    if (rst || eng_abort) begin
      e_st = 0;
      eng_if.conv_kernel_ready = 1'b0;
      eng_if.conv_out_valid    = 1'b0;
      eng_if.conv_out_last     = 1'b0;
      eng_if.conv_out_elem     = '0;
      eng_if.conv_out_row_idx  = '0;
      eng_if.conv_out_col_idx  = '0;
    end else if (eng_if.conv_start) begin
      e_st = 1; nk = 0; t_s = cyc; n_start++;
      eng_if.conv_kernel_ready = 1'b0;
      eng_if.conv_out_valid    = 1'b0;
      eng_if.conv_out_last     = 1'b0;
    end else if (e_st == 1) begin
      rdy = (mode != 1) && ($urandom_range(3) != 0);
      eng_if.conv_kernel_ready = rdy;
      if (rdy && eng_if.conv_kernel_valid) begin
        if (exp_kq.size() == 0) chk("kern_unexpected", 1, 0);
        else chk($sformatf("kern%0d", nk), int'(eng_if.conv_kernel), exp_kq.pop_front());
        krx[nk] = int'(eng_if.conv_kernel);
        nk++;
        if (nk == 9) begin e_st = 2; ridx = 0; end
      end
    end else if (e_st == 2) begin
      eng_if.conv_kernel_ready = 1'b0;
      ntot = (mode == 2) ? 50 : (mode == 3) ? 1 : 80;
      if (ridx >= ntot) begin
        eng_if.conv_out_valid = 1'b0;
        eng_if.conv_out_last  = 1'b0;
        e_st = 0;
      end else if ($urandom_range(3) != 0) begin
        eng_if.conv_out_valid = 1'b1;
        if (mode == 3) begin
          eng_if.conv_out_row_idx = 4'd1;
          eng_if.conv_out_col_idx = 4'd12;
          eng_if.conv_out_elem    = AW'(123);
          eng_if.conv_out_last    = 1'b0;
        end else begin
          eng_if.conv_out_row_idx = 4'(ridx / 10);
          eng_if.conv_out_col_idx = 4'(ridx % 10);
          eng_if.conv_out_elem    = AW'(conv_k(krx, ridx));
          refbuf[ridx]            = conv_k(kmodel, ridx);
          eng_if.conv_out_last    = (ridx == ntot - 1);
          if (ridx == ntot - 1) t_l = cyc;
        end
        ridx++;
      end else begin
        eng_if.conv_out_valid = 1'b0;
        eng_if.conv_out_last  = 1'b0;
      end
    end else begin
      eng_if.conv_kernel_ready = 1'b0;
      eng_if.conv_out_valid    = 1'b0;
      eng_if.conv_out_last     = 1'b0;
    end
  end

  // Read scoreboard monitor: a read issued before an edge is checked just after it.
  initial begin : rd_mon
    bit v;
    int a, e;
    forever begin
      @(posedge clk);
      v = rd_req;
      #1;
      if (v) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          a = rd_aq.pop_front();
          e = rd_q.pop_front();
          chk($sformatf("rd[%0d]", a), int'(rd_data), e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic kwrite(input int a, input int d, input bit applies);
    kwa = 4'(a); kwd = 4'(d); kwe = 1'b1;
    if (applies && a <= 8) kmodel[a] = d;
    @(negedge clk);
    kwe = 1'b0;
  endtask

  task automatic start_run(input bit wr, input int a, input int d);
    if (wr) begin
      kwa = 4'(a); kwd = 4'(d); kwe = 1'b1;
      if (a <= 8) kmodel[a] = d;
    end
    for (int i = 0; i < 9; i++) exp_kq.push_back(kmodel[i]);
    req_run = 1'b1;
    n_runs++;
    @(negedge clk);
    req_run = 1'b0;
    kwe = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int maxc);
    int n = 0;
    while (busy === 1'b1 && n < maxc) begin @(negedge clk); n++; end
    chk({nm, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic rd(input int a, input int e);
    rd_addr = 7'(a); rd_req = 1'b1;
    rd_aq.push_back(a); rd_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a, n;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 12; c++) img[r][c] = $urandom_range(9);
    // Top-left 3x3 sums to 40 with centre 1; pixel (8,10) is 6.
    img[0][0] = 5; img[0][1] = 5; img[0][2] = 5;
    img[1][0] = 5; img[1][1] = 1; img[1][2] = 5;
    img[2][0] = 5; img[2][1] = 5; img[2][2] = 4;
    img[8][10] = 6;
    for (int i = 0; i < 9; i++) kmodel[i] = 0;

    // Reset state
    rst = 1'b1;
    step(3);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_count", int'(rcount), 0);
    chk("rst_cycles", int'(rcyc), 0);
    rst = 1'b0;
    step(1);
    chk("rst_start", int'(eng_if.conv_start), 0);
    chk("rst_kvalid", int'(eng_if.conv_kernel_valid), 0);

    // All-ones kernel, full run
    mode = 0;
    for (int i = 0; i < 9; i++) kwrite(i, 1, 1);
    start_run(0, 0, 0);
    chk("t1_busy", int'(busy), 1);
    wait_end("t1", 3000);
    chk("t1_done", int'(done), 1);
    chk("t1_err", int'(err), 0);
    chk("t1_count", int'(rcount), 80);
    chk("t1_cycles", int'(rcyc), t_l - t_s);
    rd(0, 40);
    for (int i = 0; i < 80; i++) rd(i, refbuf[i]);
    rd(100, 0);

    // Centre-only kernel; out-of-range kernel address ignored
    for (int i = 0; i < 9; i++) kwrite(i, (i == 4) ? 1 : 0, 1);
    kwrite(12, 5, 0);
    start_run(0, 0, 0);
    wait_end("t2", 3000);
    chk("t2_done", int'(done), 1);
    chk("t2_count", int'(rcount), 80);
    chk("t2_cycles", int'(rcyc), t_l - t_s);
    rd(0, 1);
    rd(79, 6);
    rd(100, 0);
    for (int i = 0; i < 6; i++) begin a = $urandom_range(79); rd(a, refbuf[a]); end
    for (int i = 0; i < 3; i++) rd($urandom_range(127, 80), 0);

    // Early last after 50 results; req_run and kernel write mid-run ignored
    for (int i = 0; i < 9; i++) kwrite(i, $urandom_range(9), 1);
    mode = 2;
    start_run(0, 0, 0);
    step(2);
    req_run = 1'b1; kwa = 4'd0; kwd = 4'd9; kwe = 1'b1;
    step(1);
    req_run = 1'b0; kwe = 1'b0;
    wait_end("t3", 3000);
    chk("t3_err", int'(err), 1);
    chk("t3_done", int'(done), 0);
    chk("t3_count", int'(rcount), 50);
    for (int i = 0; i < 4; i++) begin a = $urandom_range(49); rd(a, refbuf[a]); end

    // Engine never ready: idle timeout
    mode = 1;
    start_run(0, 0, 0);
    step(TO - 4);
    chk("t4_err_early", int'(err), 0);
    chk("t4_busy_early", int'(busy), 1);
    wait_end("t4", TO + 20);
    chk("t4_err", int'(err), 1);
    exp_kq.delete();
    // Clean restart with the kernel that the ignored write left untouched
    mode = 0;
    start_run(0, 0, 0);
    wait_end("t4b", 3000);
    chk("t4b_done", int'(done), 1);
    chk("t4b_err", int'(err), 0);
    chk("t4b_count", int'(rcount), 80);
    chk("t4b_cycles", int'(rcyc), t_l - t_s);
    rd(33, refbuf[33]);

    // Out-of-range result index: error, no buffer write
    mode = 3;
    start_run(0, 0, 0);
    wait_end("t5", 3000);
    chk("t5_err", int'(err), 1);
    chk("t5_count", int'(rcount), 0);
    rd(22, refbuf[22]);

    // Reset in the middle of COLLECT
    mode = 0;
    start_run(0, 0, 0);
    n = 0;
    while (!(e_st == 2 && ridx >= 20) && n < 1000) begin step(1); n++; end
    chk("t6_reached_collect", int'(e_st == 2 && ridx >= 20), 1);
    eng_abort = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_err", int'(err), 0);
    chk("t6_count", int'(rcount), 0);
    chk("t6_cycles", int'(rcyc), 0);
    chk("t6_rd_data", int'(rd_data), 0);
    step(1);
    chk("t6_start", int'(eng_if.conv_start), 0);
    chk("t6_kvalid", int'(eng_if.conv_kernel_valid), 0);
    eng_abort = 1'b0;
    exp_kq.delete();
    for (int i = 0; i < 9; i++) kmodel[i] = 0;
    // Kernel write together with req_run from IDLE: new value is fed
    start_run(1, 0, 7);
    wait_end("t7", 3000);
    chk("t7_done", int'(done), 1);
    chk("t7_count", int'(rcount), 80);
    chk("t7_cycles", int'(rcyc), t_l - t_s);
    rd(0, 35);
    for (int i = 0; i < 8; i++) begin a = $urandom_range(79); rd(a, refbuf[a]); end

    step(3);
    chk("kern_q_left", exp_kq.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    chk("start_pulses", n_start, n_runs);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
